// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: operand forwarding mux, bubble/kill/hold control and front-end stalls.
// Optional bubble counter enabled by defining BUBBLE_CNT_EN.
module id_ex_pipe_reg #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ALUOP_W = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [XLEN-1:0]    id_rd1,
   input  logic [XLEN-1:0]    id_rd2,
   input  logic [XLEN-1:0]    id_imm,
   input  logic [4:0]         id_wR,
   input  logic               id_rf_we,
   input  logic [1:0]         id_wd_sel,
   input  logic [ALUOP_W-1:0] id_alu_op,
   input  logic [6:0]         id_op,
   input  logic               risk_con1,
   input  logic               risk_con2,
   input  logic [XLEN-1:0]    risk_rd1,
   input  logic [XLEN-1:0]    risk_rd2,
   input  logic               Lu_pipeline_stop,
   input  logic               ex_flush,
   input  logic               mem_hold,
   output logic               EX_valid,
   output logic [XLEN-1:0]    EX_pc,
   output logic [XLEN-1:0]    EX_A,
   output logic [XLEN-1:0]    EX_B,
   output logic [XLEN-1:0]    EX_imm,
   output logic [4:0]         EX_wR,
   output logic               EX_rf_we,
   output logic [1:0]         EX_wd_sel,
   output logic [ALUOP_W-1:0] EX_alu_op,
   output logic [6:0]         EX_op,
`ifdef BUBBLE_CNT_EN
   output logic [CNT_W-1:0]   bubble_cnt,
`endif
   output logic               pc_stall,
   output logic               ifid_stall
);

   logic [XLEN-1:0]    w_a;
   logic [XLEN-1:0]    w_b;
   logic               w_bubble;

   logic               r_valid;
   logic [XLEN-1:0]    r_pc;
   logic [XLEN-1:0]    r_a;
   logic [XLEN-1:0]    r_b;
   logic [XLEN-1:0]    r_imm;
   logic [4:0]         r_wr;
   logic               r_rf_we;
   logic [1:0]         r_wd_sel;
   logic [ALUOP_W-1:0] r_alu_op;
   logic [6:0]         r_op;

   always_comb begin
      w_a      = risk_con1 ? risk_rd1 : id_rd1;
      w_b      = risk_con2 ? risk_rd2 : id_rd2;
      w_bubble = ex_flush | Lu_pipeline_stop;
      // A flushed instruction is dead, so its load-use stall must not freeze the front end.
      pc_stall   = mem_hold | (Lu_pipeline_stop & ~ex_flush);
      ifid_stall = mem_hold | (Lu_pipeline_stop & ~ex_flush);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_imm    <= '0;
         r_wr     <= '0;
         r_rf_we  <= 1'b0;
         r_wd_sel <= '0;
         r_alu_op <= '0;
         r_op     <= '0;
      end else if (mem_hold) begin
         r_valid  <= r_valid;
      end else if (w_bubble) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_imm    <= '0;
         r_wr     <= '0;
         r_rf_we  <= 1'b0;
         r_wd_sel <= '0;
         r_alu_op <= '0;
         r_op     <= '0;
      end else begin
         r_valid  <= id_valid;
         r_pc     <= id_pc;
         r_a      <= w_a;
         r_b      <= w_b;
         r_imm    <= id_imm;
         r_wr     <= id_wR;
         r_rf_we  <= id_rf_we & id_valid;
         r_wd_sel <= id_wd_sel;
         r_alu_op <= id_alu_op;
         r_op     <= id_op;
      end
   end

`ifdef BUBBLE_CNT_EN
   logic [CNT_W-1:0] r_bubble_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bubble_cnt <= '0;
      end else if (!mem_hold && w_bubble) begin
         r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
   end

   assign bubble_cnt = r_bubble_cnt;
`endif

   assign EX_valid  = r_valid;
   assign EX_pc     = r_pc;
   assign EX_A      = r_a;
   assign EX_B      = r_b;
   assign EX_imm    = r_imm;
   assign EX_wR     = r_wr;
   assign EX_rf_we  = r_rf_we;
   assign EX_wd_sel = r_wd_sel;
   assign EX_alu_op = r_alu_op;
   assign EX_op     = r_op;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg against a cycle-level behavioural model.
// Checks bubble_cnt only when BUBBLE_CNT_EN is defined.
module tb_id_ex_pipe_reg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned ALUOP_W = 4;
   localparam int unsigned CNT_W   = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               id_valid = 1'b0;
   logic [XLEN-1:0]    id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
   logic [4:0]         id_wR = '0;
   logic               id_rf_we = 1'b0;
   logic [1:0]         id_wd_sel = '0;
   logic [ALUOP_W-1:0] id_alu_op = '0;
   logic [6:0]         id_op = '0;
   logic               risk_con1 = 1'b0, risk_con2 = 1'b0;
   logic [XLEN-1:0]    risk_rd1 = '0, risk_rd2 = '0;
   logic               Lu_pipeline_stop = 1'b0, ex_flush = 1'b0, mem_hold = 1'b0;

   logic               EX_valid, EX_rf_we, pc_stall, ifid_stall;
   logic [XLEN-1:0]    EX_pc, EX_A, EX_B, EX_imm;
   logic [4:0]         EX_wR;
   logic [1:0]         EX_wd_sel;
   logic [ALUOP_W-1:0] EX_alu_op;
   logic [6:0]         EX_op;
`ifdef BUBBLE_CNT_EN
   logic [CNT_W-1:0]   bubble_cnt;
`endif

   id_ex_pipe_reg #(.XLEN(XLEN), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1),
      .id_rd2(id_rd2), .id_imm(id_imm), .id_wR(id_wR), .id_rf_we(id_rf_we),
      .id_wd_sel(id_wd_sel), .id_alu_op(id_alu_op), .id_op(id_op),
      .risk_con1(risk_con1), .risk_con2(risk_con2), .risk_rd1(risk_rd1),
      .risk_rd2(risk_rd2), .Lu_pipeline_stop(Lu_pipeline_stop), .ex_flush(ex_flush),
      .mem_hold(mem_hold), .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_A(EX_A), .EX_B(EX_B),
      .EX_imm(EX_imm), .EX_wR(EX_wR), .EX_rf_we(EX_rf_we), .EX_wd_sel(EX_wd_sel),
      .EX_alu_op(EX_alu_op), .EX_op(EX_op),
`ifdef BUBBLE_CNT_EN
      .bubble_cnt(bubble_cnt),
`endif
      .pc_stall(pc_stall), .ifid_stall(ifid_stall)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model of the EX-stage contents, as a single packed record.
   typedef struct packed {
      logic               valid;
      logic [XLEN-1:0]    pc, a, b, imm;
      logic [4:0]         wr;
      logic               we;
      logic [1:0]         wd_sel;
      logic [ALUOP_W-1:0] alu;
      logic [6:0]         op;
   } ex_t;

   ex_t            m_ex = '0;
   logic [CNT_W-1:0] m_cnt = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("EX_valid", 64'(EX_valid), 64'(m_ex.valid));
      chk("EX_pc", 64'(EX_pc), 64'(m_ex.pc));
      chk("EX_A", 64'(EX_A), 64'(m_ex.a));
      chk("EX_B", 64'(EX_B), 64'(m_ex.b));
      chk("EX_imm", 64'(EX_imm), 64'(m_ex.imm));
      chk("EX_wR", 64'(EX_wR), 64'(m_ex.wr));
      chk("EX_rf_we", 64'(EX_rf_we), 64'(m_ex.we));
      chk("EX_wd_sel", 64'(EX_wd_sel), 64'(m_ex.wd_sel));
      chk("EX_alu_op", 64'(EX_alu_op), 64'(m_ex.alu));
      chk("EX_op", 64'(EX_op), 64'(m_ex.op));
`ifdef BUBBLE_CNT_EN
      chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
`endif
   endtask

   // One clock: check stall lines on current inputs, advance model, then check registered state.
   task automatic step();
      logic exp_stall;
      #1;
      exp_stall = mem_hold || (Lu_pipeline_stop && !ex_flush);
      chk("pc_stall", 64'(pc_stall), 64'(exp_stall));
      chk("ifid_stall", 64'(ifid_stall), 64'(exp_stall));
      if (mem_hold) begin
         m_ex = m_ex;
      end else if (ex_flush || Lu_pipeline_stop) begin
         m_ex  = '0;
         m_cnt = m_cnt + 1'b1;
      end else begin
         m_ex.valid  = id_valid;
         m_ex.pc     = id_pc;
         m_ex.a      = risk_con1 ? risk_rd1 : id_rd1;
         m_ex.b      = risk_con2 ? risk_rd2 : id_rd2;
         m_ex.imm    = id_imm;
         m_ex.wr     = id_wR;
         m_ex.we     = id_valid && id_rf_we;
         m_ex.wd_sel = id_wd_sel;
         m_ex.alu    = id_alu_op;
         m_ex.op     = id_op;
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] wr,
                         input logic we, input logic [1:0] sel, input logic [3:0] alu,
                         input logic [6:0] op);
      id_valid = v; id_pc = pc; id_rd1 = r1; id_rd2 = r2; id_imm = imm;
      id_wR = wr; id_rf_we = we; id_wd_sel = sel; id_alu_op = alu; id_op = op;
   endtask

   task automatic async_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      m_ex  = '0;
      m_cnt = '0;
      compare_all();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3;
      compare_all();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Forwarding select on A and B
      set_id(1, 32'h100, 32'd5, 32'd9, 32'h44, 5'd3, 1, 2'b00, 4'h2, 7'h33);
      risk_con1 = 1; risk_rd1 = 32'h1234;
      step();
      chk("T2 fwd A", 64'(EX_A), 64'h1234);
      risk_con1 = 0;
      step();
      chk("T2 rf A", 64'(EX_A), 64'd5);
      risk_con2 = 1; risk_rd2 = 32'hBEEF;
      step();
      chk("fwd B", 64'(EX_B), 64'hBEEF);
      risk_con2 = 0;

      // Load-use bubble then reload of the same ID instruction
      set_id(1, 32'h104, 32'd1, 32'd2, 32'h8, 5'd7, 1, 2'b01, 4'h0, 7'h03);
      Lu_pipeline_stop = 1;
      #1;
      chk("T3 pc_stall", 64'(pc_stall), 64'd1);
      step();
      chk("T3 bubble we", 64'(EX_rf_we), 64'd0);
      chk("T3 bubble valid", 64'(EX_valid), 64'd0);
      Lu_pipeline_stop = 0;
      step();
      chk("T3 reload wR", 64'(EX_wR), 64'd7);

      // Invalid ID must not produce a write-back
      set_id(0, 32'h108, 32'd3, 32'd4, 32'h0, 5'd9, 1, 2'b11, 4'h1, 7'h13);
      step();
      chk("invalid we", 64'(EX_rf_we), 64'd0);

      // Flush with load-use: bubble but no front-end stall
      set_id(1, 32'h10C, 32'd6, 32'd7, 32'h1, 5'd4, 1, 2'b00, 4'h3, 7'h33);
      ex_flush = 1; Lu_pipeline_stop = 1;
      #1;
      chk("T4 pc_stall", 64'(pc_stall), 64'd0);
      step();
      ex_flush = 0; Lu_pipeline_stop = 0;

      // Load something, then hold three cycles with a flush pulse in the middle
      set_id(1, 32'h200, 32'hA, 32'hB, 32'hC, 5'd12, 1, 2'b11, 4'h5, 7'h37);
      step();
      mem_hold = 1;
      set_id(1, 32'h204, 32'hD, 32'hE, 32'hF, 5'd13, 1, 2'b00, 4'h6, 7'h13);
      risk_con1 = 1; risk_rd1 = 32'h5555;
      for (int i = 0; i < 3; i++) begin
         ex_flush = (i == 1);
         #1;
         chk("T5 pc_stall", 64'(pc_stall), 64'd1);
         step();
      end
      chk("T5 held pc", 64'(EX_pc), 64'h200);
      mem_hold = 0; ex_flush = 0; risk_con1 = 0;

      // Assorted directed/pseudo-random vectors
      for (int i = 0; i < 12; i++) begin
         set_id(1'($urandom), $urandom, $urandom, $urandom, $urandom, 5'($urandom),
                1'($urandom), 2'($urandom), 4'($urandom), 7'($urandom));
         risk_con1 = 1'($urandom); risk_rd1 = $urandom;
         risk_con2 = 1'($urandom); risk_rd2 = $urandom;
         mem_hold = ($urandom_range(0, 3) == 0);
         ex_flush = ($urandom_range(0, 4) == 0);
         Lu_pipeline_stop = ($urandom_range(0, 3) == 0);
         step();
      end
      mem_hold = 0; ex_flush = 0; Lu_pipeline_stop = 0;

      // Asynchronous reset while EX holds a valid instruction
      set_id(1, 32'h300, 32'h1, 32'h2, 32'h3, 5'd5, 1, 2'b00, 4'h1, 7'h33);
      step();
      chk("T1 pre valid", 64'(EX_valid), 64'd1);
      async_reset();

      // Five bubbles from reset on a 2-bit counter wrap to 1
      Lu_pipeline_stop = 1;
      for (int i = 0; i < 5; i++) step();
      Lu_pipeline_stop = 0;
`ifdef BUBBLE_CNT_EN
      chk("T6 wrap", 64'(bubble_cnt), 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

endmodule
